// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, GF(2^8) helpers, round constants and state typing.
package aes_pkg;

    localparam int AES_NR = 10;

    // Column-major block view: [column][row], byte 0 of the block is [0][0] at the MSB end.
    typedef logic [0:3][0:3][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_ROUND,
        ST_FINAL
    } enc_st_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // Column bytes a0..a3 are rows 0..3, a0 in the top byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One forward AES round, purely combinational: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         is_final,
    output logic [127:0] state_out
);

    aes_state_t s_in;
    aes_state_t s_sub;
    aes_state_t s_shift;
    aes_state_t s_mix;

    assign s_in = aes_state_t'(state_in);

    always_comb begin
        s_sub   = '0;
        s_shift = '0;
        s_mix   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s_sub[c][r] = sbox(s_in[c][r]);
            end
        end
        // Row r rotates left by r: the byte landing in column c comes from column c+r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s_shift[c][r] = s_sub[(c + r) % 4][r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            s_mix[c] = mix_col(s_shift[c]);
        end
        state_out = (is_final ? 128'(s_shift) : 128'(s_mix)) ^ round_key;
    end

endmodule

// File: rtl/aes_cipher_enc.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
//
//  state | meaning
//  IDLE  | waiting for ld; round counter parked at 0
//  INIT  | block and key captured; AddRoundKey 0 on the next edge
//  ROUND | rounds 1..NR-1 with MixColumns, key schedule advances each edge
//  FINAL | round NR into the state register, then published to text_out with done
module aes_cipher_enc
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] text_out
);

    if (NR != AES_NR) begin : g_nr_check
        $fatal(1, "aes_cipher_enc: only NR=10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST_MID_RND = 4'(NR - 1);

    enc_st_e      fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         fin_q, fin_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [127:0] text_out_q, text_out_d;

    logic [31:0]  w0, w1, w2, w3, t_w;
    logic [127:0] rk_next;
    logic [127:0] round_out;

    always_comb begin
        w0      = rk_q[127:96];
        w1      = rk_q[95:64];
        w2      = rk_q[63:32];
        w3      = rk_q[31:0];
        t_w     = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd_q), 24'h0};
        rk_next = {w0 ^ t_w, w0 ^ w1 ^ t_w, w0 ^ w1 ^ w2 ^ t_w, w0 ^ w1 ^ w2 ^ w3 ^ t_w};
    end

    aes_enc_round u_round (
        .state_in  (state_q),
        .round_key (rk_next),
        .is_final  (fsm_q == ST_FINAL),
        .state_out (round_out)
    );

    always_comb begin
        fsm_d      = fsm_q;
        rnd_d      = rnd_q;
        fin_d      = fin_q;
        state_d    = state_q;
        rk_d       = rk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        text_out_d = text_out_q;

        case (fsm_q)
            ST_IDLE: begin
                rnd_d = 4'd0;
            end
            ST_INIT: begin
                state_d = state_q ^ rk_q;
                rnd_d   = 4'd1;
                busy_d  = 1'b1;
                fsm_d   = ST_ROUND;
            end
            ST_ROUND: begin
                state_d = round_out;
                rk_d    = rk_next;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == LAST_MID_RND) begin
                    fsm_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                // Two edges here: compute the last round, then publish it from the register.
                if (!fin_q) begin
                    state_d = round_out;
                    rk_d    = rk_next;
                    fin_d   = 1'b1;
                end else begin
                    text_out_d = state_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    rnd_d      = 4'd0;
                    fin_d      = 1'b0;
                    fsm_d      = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        // A new load always wins over the block in flight, including its pending publish.
        if (ld) begin
            state_d    = text_in;
            rk_d       = key;
            rnd_d      = 4'd0;
            fin_d      = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            text_out_d = text_out_q;
            fsm_d      = ST_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= ST_IDLE;
            rnd_q      <= 4'd0;
            fin_q      <= 1'b0;
            state_q    <= '0;
            rk_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            text_out_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            rnd_q      <= rnd_d;
            fin_q      <= fin_d;
            state_q    <= state_d;
            rk_q       <= rk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            text_out_q <= text_out_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign text_out = text_out_q;

endmodule

// File: tb/tb_aes_cipher_enc.sv
// Directed and random checks of aes_cipher_enc against a byte-level AES model built from GF(2^8) math.
module tb_aes_cipher_enc;

    localparam logic [127:0] V1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V1P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V2P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V2C = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V3C = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk;
    logic         rst;
    logic         ld;
    logic [127:0] key;
    logic [127:0] text_in;
    logic         busy;
    logic         done;
    logic [127:0] text_out;

    int n_chk;
    int n_fail;

    logic [7:0] sb_t  [256];
    logic [7:0] isb_t [256];

    aes_cipher_enc #(.NR(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .key      (key),
        .text_in  (text_in),
        .busy     (busy),
        .done     (done),
        .text_out (text_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] v, inv, s;
            v   = 8'(x);
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, v);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb_t[x]  = s;
            isb_t[s] = v;
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] v, input int i);
        return v[127 - 8*i -: 8];
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Byte index is 4*column+row; inverse direction undoes the row rotation and the S-box.
    function automatic logic [127:0] sub_shift(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        logic [7:0]   b;
        int           src;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                src = inv ? 4*((c - rr + 4) % 4) + rr : 4*((c + rr) % 4) + rr;
                b   = gb(s, src);
                r[127 - 8*(4*c + rr) -: 8] = inv ? isb_t[b] : sb_t[b];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] mcoef(input int d, input bit inv);
        case (d)
            0:       return inv ? 8'd14 : 8'd2;
            1:       return inv ? 8'd11 : 8'd3;
            2:       return inv ? 8'd13 : 8'd1;
            default: return inv ? 8'd9  : 8'd1;
        endcase
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(mcoef((j - i + 4) % 4, inv), gb(s, 4*c + j));
                r[127 - 8*(4*c + i) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] s;
        s = p ^ round_key(k, 0);
        for (int r = 1; r <= 10; r++) begin
            s = sub_shift(s, 1'b0);
            if (r < 10) s = mix(s, 1'b0);
            s = s ^ round_key(k, r);
        end
        return s;
    endfunction

    function automatic logic [127:0] dec(input logic [127:0] k, input logic [127:0] c);
        logic [127:0] s;
        s = c ^ round_key(k, 10);
        for (int r = 9; r >= 0; r--) begin
            s = sub_shift(s, 1'b1);
            s = s ^ round_key(k, r);
            if (r > 0) s = mix(s, 1'b1);
        end
        return s;
    endfunction

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic start(input logic [127:0] k, input logic [127:0] p);
        ld      = 1'b1;
        key     = k;
        text_in = p;
    endtask

    // lat counts edges after the load edge; inputs are scrambled once ld drops.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (i == 0) begin
                ld      = 1'b0;
                key     = {$urandom(), $urandom(), $urandom(), $urandom()};
                text_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) break;
        end
        chk("done_seen", 128'(done), 128'(1'b1));
    endtask

    initial begin
        int lat, bcnt;
        logic [127:0] k_cur, p_cur, ct_exp;

        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        ld      = 1'b0;
        key     = '0;
        text_in = '0;
        build_sbox();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_text_out", text_out, 128'h0);
        rst = 1'b0;

        // Vector 1: fixed latency and known ciphertext.
        start(V1K, V1P);
        wait_done(lat, bcnt);
        chk("v1_latency", 128'(lat), 128'(12));
        chk("v1_ct", text_out, V1C);
        chk("v1_busy_low_at_done", 128'(busy), 128'(1'b0));
        @(negedge clk);
        chk("v1_done_single", 128'(done), 128'(1'b0));
        chk("v1_hold", text_out, V1C);

        // Vector 2: busy window length.
        start(V2K, V2P);
        wait_done(lat, bcnt);
        chk("v2_ct", text_out, V2C);
        chk("v2_busy_cycles", 128'(bcnt), 128'(11));
        chk("v2_latency", 128'(lat), 128'(12));

        // All-zero key and block, then a long idle stretch.
        @(negedge clk);
        start('0, '0);
        wait_done(lat, bcnt);
        chk("v3_ct", text_out, V3C);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_done_low", 128'(done), 128'(1'b0));
            chk("idle_text_held", text_out, V3C);
        end

        // Restart while busy: only the second block completes, timed from its own load.
        start(V1K, V1P);
        @(posedge clk);
        @(negedge clk);
        ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_early_done", 128'(done), 128'(1'b0));
        end
        chk("abort_busy_high", 128'(busy), 128'(1'b1));
        start(V2K, V2P);
        @(posedge clk);
        @(negedge clk);
        ld = 1'b0;
        chk("abort_text_held", text_out, V3C);
        chk("abort_restart_busy_low", 128'(busy), 128'(1'b0));
        wait_done(lat, bcnt);
        chk("abort_latency", 128'(lat), 128'(11));
        chk("abort_ct", text_out, V2C);
        @(negedge clk);
        chk("abort_done_single", 128'(done), 128'(1'b0));

        // Reset mid-block, with a simultaneous load that must be ignored.
        start(V1K, V1P);
        @(posedge clk);
        @(negedge clk);
        ld = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        start(V2K, V2P);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ld  = 1'b0;
        chk("midrst_busy", 128'(busy), 128'(1'b0));
        chk("midrst_done", 128'(done), 128'(1'b0));
        chk("midrst_text_out", text_out, 128'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 128'(done), 128'(1'b0));
            chk("midrst_no_busy", 128'(busy), 128'(1'b0));
        end
        start(V1K, V1P);
        wait_done(lat, bcnt);
        chk("postrst_ct", text_out, V1C);
        chk("postrst_latency", 128'(lat), 128'(12));

        // Back-to-back random blocks, each load issued in the previous block's done cycle.
        @(negedge clk);
        k_cur = {$urandom(), $urandom(), $urandom(), $urandom()};
        p_cur = {$urandom(), $urandom(), $urandom(), $urandom()};
        start(k_cur, p_cur);
        for (int n = 0; n < 100; n++) begin
            wait_done(lat, bcnt);
            ct_exp = enc(k_cur, p_cur);
            chk("rand_ct", text_out, ct_exp);
            chk("rand_latency", 128'(lat), 128'(12));
            chk("rand_roundtrip", dec(k_cur, text_out), p_cur);
            if (n < 99) begin
                k_cur = {$urandom(), $urandom(), $urandom(), $urandom()};
                p_cur = {$urandom(), $urandom(), $urandom(), $urandom()};
                start(k_cur, p_cur);
            end
        end
        @(negedge clk);
        chk("rand_done_single", 128'(done), 128'(1'b0));
        chk("rand_text_held", text_out, ct_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
